// File: rtl/dff_write_arbiter.sv
// ============================================================================
// Module  : dff_write_arbiter
// Brief   : 4-way round-robin REQ/ACK arbiter writing one shared WIDTH-bit register
// Revision: 1.0
// ============================================================================
`default_nettype none

module dff_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [3:0]           REQ,
    input  logic [4*WIDTH-1:0]   D_IN,
    output logic [3:0]           ACK,
    output logic [1:0]           GNT_ID,
    output logic [WIDTH-1:0]     Q,
    output logic                 Q_VALID,
    output logic                 BUSY,
    output logic [CNT_W-1:0]     WR_CNT
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;

    logic [7:0]       w_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_win;
    logic             w_any;
    logic [WIDTH-1:0] w_slice [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_slice[gi] = D_IN[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so bit 0 is the pointer position; lowest set bit is the winner offset.
    assign w_dbl = {REQ, REQ} >> r_ptr;
    assign w_rot = w_dbl[3:0];
    assign w_any = |REQ;

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign w_win = r_ptr + w_off;
    assign BUSY  = (r_state == S_HOLD);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            ACK     <= 4'd0;
            GNT_ID  <= 2'd0;
            Q       <= '0;
            Q_VALID <= 1'b0;
            WR_CNT  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        Q       <= w_slice[w_win];
                        GNT_ID  <= w_win;
                        ACK     <= 4'b0001 << w_win;
                        r_ptr   <= w_win + 2'd1;
                        Q_VALID <= 1'b1;
                        WR_CNT  <= WR_CNT + 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Only the grantee's request line can close the transaction.
                    if (!REQ[GNT_ID]) begin
                        ACK     <= 4'd0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
// ============================================================================
// Module  : tb_dff_write_arbiter
// Brief   : directed self-checking bench for dff_write_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dff_write_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic                CLK;
    logic                RST_N;
    logic [3:0]          REQ;
    logic [4*WIDTH-1:0]  D_IN;
    logic [3:0]          ACK;
    logic [1:0]          GNT_ID;
    logic [WIDTH-1:0]    Q;
    logic                Q_VALID;
    logic                BUSY;
    logic [CNT_W-1:0]    WR_CNT;

    int total = 0;
    int bad   = 0;

    dff_write_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .D_IN    (D_IN),
        .ACK     (ACK),
        .GNT_ID  (GNT_ID),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .BUSY    (BUSY),
        .WR_CNT  (WR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Checks a freshly opened grant to requester id carrying data d.
    task automatic chk_grant(input string tag, input int id, input logic [7:0] d);
        chk({tag, "_ack"}, 32'(ACK), 32'(4'b0001 << id));
        chk({tag, "_gnt"}, 32'(GNT_ID), 32'(id));
        chk({tag, "_q"},   32'(Q), 32'(d));
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b1;
        REQ   = 4'd0;
        D_IN  = '0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_ack",  32'(ACK), 32'd0);
        chk("rst_gnt",  32'(GNT_ID), 32'd0);
        chk("rst_q",    32'(Q), 32'd0);
        chk("rst_qv",   32'(Q_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_cnt",  32'(WR_CNT), 32'd0);
        tick();
        RST_N = 1'b1;

        // Single request
        REQ = 4'b0001;
        D_IN[7:0] = 8'hA5;
        tick();
        chk_grant("single", 0, 8'hA5);
        chk("single_qv",  32'(Q_VALID), 32'd1);
        chk("single_cnt", 32'(WR_CNT), 32'd1);
        REQ = 4'b0000;
        tick();
        chk("single_rel_ack",  32'(ACK), 32'd0);
        chk("single_rel_busy", 32'(BUSY), 32'd0);
        tick();
        chk("idle_hold_q", 32'(Q), 32'hA5);

        // Round robin with all four requesting, from PTR = 0
        pulse_reset();
        for (int i = 0; i < 4; i++) D_IN[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
        REQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_grant("rr", n % 4, 8'h10 + 8'(n % 4));
            REQ[n % 4] = 1'b0;
            tick();
            chk("rr_rel_ack", 32'(ACK), 32'd0);
            chk("rr_rel_busy", 32'(BUSY), 32'd0);
            REQ = 4'b1111;
        end
        REQ = 4'b0000;
        tick();
        chk("rr_cnt", 32'(WR_CNT), 32'd5);

        // Pointer priority: grant 2 -> PTR 3, then 0101 picks 0, then 0100 picks 2
        REQ = 4'b0100;
        tick();
        chk_grant("pp_a", 2, 8'h12);
        REQ = 4'b0000;
        tick();
        REQ = 4'b0101;
        tick();
        chk_grant("pp_b", 0, 8'h10);
        REQ = 4'b0000;
        tick();
        REQ = 4'b0100;
        tick();
        chk_grant("pp_c", 2, 8'h12);

        // Data stability during HOLD
        D_IN[2*WIDTH +: WIDTH] = 8'hFF;
        REQ = 4'b1111;
        tick();
        REQ = 4'b0110;
        tick();
        chk_grant("stab", 2, 8'h12);

        // Asynchronous reset between edges while ACK = 0100
        RST_N = 1'b0;
        #2;
        chk("arst_ack",  32'(ACK), 32'd0);
        chk("arst_q",    32'(Q), 32'd0);
        chk("arst_qv",   32'(Q_VALID), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_cnt",  32'(WR_CNT), 32'd0);
        RST_N = 1'b1;
        REQ = 4'b1010;
        tick();
        chk_grant("arst_rel", 1, 8'h11);
        REQ = 4'b0000;
        tick();

        // Counter wrap
        pulse_reset();
        for (int n = 1; n <= 257; n++) begin
            REQ = 4'b0001;
            tick();
            if (n == 255) chk("wrap_255", 32'(WR_CNT), 32'd255);
            if (n == 256) chk("wrap_256", 32'(WR_CNT), 32'd0);
            if (n == 257) chk("wrap_257", 32'(WR_CNT), 32'd1);
            REQ = 4'b0000;
            tick();
        end
        chk("wrap_qv", 32'(Q_VALID), 32'd1);
        chk("wrap_q",  32'(Q), 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
